alu_sched: RTL and testbench

Sequencer and two-port arbiter for the shared `alu` datapath. Accepts operation requests from two requesters (port 0: core pipeline, port 1: auxiliary/debug master) and grants the single ALU round-robin. It latches the operands, drives the ALU for exactly one cycle and registers the result. It returns the result to the owning requester over a valid/ready response channel. Divide-by-zero is trapped here and never presented to the ALU.

---
 rtl/alu_sched.sv | 150 +++++++++++++++
 tb/tb_alu_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: two-port round-robin sequencer for the shared ALU with divide-by-zero trap.
// Optional macro ALU_SCHED_LOCK_EN adds lock0/lock1 so an owner can keep tie priority.
module alu_sched #(
    parameter int DATA_W = 32,
    parameter int OP_W = 5,
    parameter logic [OP_W-1:0] ALUOP_DIV = OP_W'(4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_aluop,
    input  logic [DATA_W-1:0] req0_val1,
    input  logic [DATA_W-1:0] req0_val2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_aluop,
    input  logic [DATA_W-1:0] req1_val1,
    input  logic [DATA_W-1:0] req1_val2,
`ifdef ALU_SCHED_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_val1,
    output logic [DATA_W-1:0] alu_val2,
    output logic [OP_W-1:0]   alu_aluop,
    output logic              alu_is_op,
    input  logic [DATA_W-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q;
    logic                owner_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   val1_q, val2_q;
    logic [DATA_W-1:0]   res_q;
    logic                err_q;

    logic                grant0, grant1;
    logic                accept;
    logic                win;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_val1, sel_val2;
    logic                div_zero;
    logic                upd_last;
    logic                rsp_fire;

    // Saturated quotient reported when the divisor is zero.
    function automatic logic [DATA_W-1:0] div_zero_result();
        return '1;
    endfunction

    // last_q names the port granted most recently; a tie goes to the other one.
    assign grant0   = req0_valid && (!req1_valid || last_q);
    assign grant1   = req1_valid && (!req0_valid || !last_q);
    assign win      = grant1;
    assign sel_op   = win ? req1_aluop : req0_aluop;
    assign sel_val1 = win ? req1_val1  : req0_val1;
    assign sel_val2 = win ? req1_val2  : req0_val2;
    assign div_zero = (sel_op == ALUOP_DIV) && (sel_val2 == '0);

`ifdef ALU_SCHED_LOCK_EN
    assign upd_last = win ? !lock1 : !lock0;
`else
    assign upd_last = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_is_op  = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so nothing looks accepted.
                accept     = rst_n && (grant0 || grant1);
                req0_ready = accept && !win;
                req1_ready = accept && win;
                if (accept)
                    state_d = div_zero ? RESP : EXEC;
            end
            EXEC: begin
                alu_is_op = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                rsp_fire   = owner_q ? rsp1_ready : rsp0_ready;
                if (rsp_fire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= sel_op;
                val1_q  <= sel_val1;
                val2_q  <= sel_val2;
                owner_q <= win;
                if (upd_last)
                    last_q <= win;
                if (div_zero) begin
                    res_q <= div_zero_result();
                    err_q <= 1'b1;
                end else begin
                    err_q <= 1'b0;
                end
            end else if (state_q == EXEC) begin
                res_q <= alu_result;
            end
        end
    end

    assign alu_val1    = val1_q;
    assign alu_val2    = val2_q;
    assign alu_aluop   = op_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: random ops against a round-robin/ALU reference model.
module tb_alu_sched;

    localparam int DATA_W = 32;
    localparam int OP_W = 5;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_BAD = 5'd31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [4:0]  req0_aluop = '0, req1_aluop = '0;
    logic [31:0] req0_val1 = '0, req0_val2 = '0, req1_val1 = '0, req1_val2 = '0;
    logic rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_val1, alu_val2, alu_result;
    logic [4:0]  alu_aluop;
    logic        alu_is_op;
`ifdef ALU_SCHED_LOCK_EN
    logic lock0 = 1'b0, lock1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int mlast = 1;

    alu_sched #(.DATA_W(DATA_W), .OP_W(OP_W), .ALUOP_DIV(OP_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_val1(req0_val1), .req0_val2(req0_val2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_val1(req1_val1), .req1_val2(req1_val2),
`ifdef ALU_SCHED_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_aluop(alu_aluop),
        .alu_is_op(alu_is_op), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU; a presented divide-by-zero yields a marker value.
    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            OP_DIV: return (b == 0) ? 32'hDEAD_BEEF : a / b;
            default: return 32'd0;
        endcase
    endfunction
    assign alu_result = alu_model(alu_aluop, alu_val1, alu_val2);

    // Expected {err, result} seen by the requester.
    function automatic logic [32:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned la, lb;
        la = a; lb = b;
        if (op == OP_DIV && b == 0) return {1'b1, 32'hFFFF_FFFF};
        case (op)
            OP_ADD: return {1'b0, 32'((la + lb) % 64'h1_0000_0000)};
            OP_SUB: return {1'b0, 32'((la + 64'h1_0000_0000 - lb) % 64'h1_0000_0000)};
            OP_MUL: return {1'b0, 32'((la * lb) % 64'h1_0000_0000)};
            OP_DIV: return {1'b0, 32'(la / lb)};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic port_ready(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction
    function automatic logic port_rsp_valid(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [32:0] port_rsp(input int p);
        return (p == 1) ? {rsp1_err, rsp1_result} : {rsp0_err, rsp0_result};
    endfunction

    logic [4:0]  pend_op [2];
    logic [31:0] pend_a  [2];
    logic [31:0] pend_b  [2];

    task automatic set_req(input int p, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        pend_op[p] = op; pend_a[p] = a; pend_b[p] = b;
        if (p == 1) begin
            req1_valid = v; req1_aluop = op; req1_val1 = a; req1_val2 = b;
        end else begin
            req0_valid = v; req0_aluop = op; req0_val1 = a; req0_val2 = b;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 1) rsp1_ready = v; else rsp0_ready = v;
    endtask

    // Runs one request on port p alone; reports response, latency and ALU-enable cycles.
    task automatic do_op(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [32:0] rsp, output int lat, output int isop_n,
                         output logic other_seen, output logic timeout);
        int n;
        lat = 0; isop_n = 0; other_seen = 1'b0; timeout = 1'b0; rsp = '0; n = 0;
        set_req(p, 1'b1, op, a, b);
        do begin
            @(negedge clk);
            n++;
        end while (!port_ready(p) && n < 50);
        if (!port_ready(p)) timeout = 1'b1;
        @(posedge clk); #1;
        set_req(p, 1'b0, op, a, b);
        if (timeout) return;
        do begin
            @(negedge clk);
            lat++;
            if (alu_is_op) isop_n++;
            if (port_rsp_valid(1 - p)) other_seen = 1'b1;
        end while (!port_rsp_valid(p) && lat < 20);
        if (!port_rsp_valid(p)) begin timeout = 1'b1; return; end
        rsp = port_rsp(p);
        set_rsp_ready(p, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
    endtask

    // With requests pending on both ports, completes whichever one is granted.
    task automatic tie_round(output int w, output logic both_ready, output logic [32:0] rsp, output logic timeout);
        int n;
        w = 0; both_ready = 1'b0; rsp = '0; timeout = 1'b0; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_ready && !req1_ready && n < 50);
        if (!req0_ready && !req1_ready) begin timeout = 1'b1; return; end
        w = req1_ready ? 1 : 0;
        both_ready = req0_ready && req1_ready;
        @(posedge clk); #1;
        set_req(w, 1'b0, pend_op[w], pend_a[w], pend_b[w]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!port_rsp_valid(w) && n < 20);
        if (!port_rsp_valid(w)) begin timeout = 1'b1; return; end
        rsp = port_rsp(w);
        set_rsp_ready(w, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(w, 1'b0);
    endtask

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 4))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_MUL;
            3: return OP_DIV;
            default: return OP_BAD;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        #12;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, alu_is_op} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, alu_is_op});
        end
        checks++;
        if ({rsp0_result, rsp1_result, alu_val1, alu_val2, alu_aluop} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h %h want 0", rsp0_result, rsp1_result, alu_val1, alu_val2, alu_aluop);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mlast = 1;
    endtask

    task automatic test_tie();
        int w, exp_w;
        logic both, to;
        logic [32:0] rsp, exp;
        set_req(0, 1'b1, OP_SUB, 32'd9, 32'd4);
        set_req(1, 1'b1, OP_MUL, 32'd3, 32'd6);
        for (int k = 0; k < 6; k++) begin
            exp_w = (mlast == 1) ? 0 : 1;
            exp = ref_model(pend_op[exp_w], pend_a[exp_w], pend_b[exp_w]);
            if (k == 0) exp = {1'b0, 32'd5};
            if (k == 1) exp = {1'b0, 32'd18};
            tie_round(w, both, rsp, to);
            checks++;
            if (to || w != exp_w || both) begin
                errors++;
                $display("FAIL tie_grant[%0d] got port %0d both=%0b timeout=%0b want port %0d", k, w, both, to, exp_w);
            end
            checks++;
            if (rsp !== exp) begin
                errors++;
                $display("FAIL tie_result[%0d] got %h want %h", k, rsp, exp);
            end
            mlast = w;
            if (k < 5)
                set_req(w, 1'b1, rand_op(), $urandom, 32'($urandom_range(0, 50)));
            else begin
                set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
                set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
            end
        end
    endtask

    task automatic test_single();
        logic [32:0] rsp;
        int lat, isop;
        logic oth, to;
        do_op(0, OP_ADD, 32'd5, 32'd7, rsp, lat, isop, oth, to);
        mlast = 0;
        checks++;
        if (to || rsp !== {1'b0, 32'd12}) begin
            errors++;
            $display("FAIL single_add got %h timeout=%0b want %h", rsp, to, {1'b0, 32'd12});
        end
        checks++;
        if (lat != 2 || isop != 1 || oth) begin
            errors++;
            $display("FAIL single_timing got lat=%0d is_op=%0d other=%0b want lat=2 is_op=1 other=0", lat, isop, oth);
        end
    endtask

    task automatic test_divzero();
        logic [32:0] rsp;
        int lat, isop;
        logic oth, to;
        do_op(1, OP_DIV, 32'd10, 32'd0, rsp, lat, isop, oth, to);
        mlast = 1;
        checks++;
        if (to || rsp !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL divzero_result got %h timeout=%0b want %h", rsp, to, {1'b1, 32'hFFFF_FFFF});
        end
        checks++;
        if (lat != 1 || isop != 0 || oth) begin
            errors++;
            $display("FAIL divzero_timing got lat=%0d is_op=%0d other=%0b want lat=1 is_op=0 other=0", lat, isop, oth);
        end
        do_op(1, OP_DIV, 32'd10, 32'd3, rsp, lat, isop, oth, to);
        checks++;
        if (to || rsp !== {1'b0, 32'd3} || lat != 2 || isop != 1) begin
            errors++;
            $display("FAIL div_normal got %h lat=%0d is_op=%0d want %h lat=2 is_op=1", rsp, lat, isop, {1'b0, 32'd3});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [32:0] exp0, exp1;
        int n;
        a = $urandom; b = $urandom;
        exp0 = ref_model(OP_ADD, a, b);
        exp1 = ref_model(OP_SUB, b, a);
        set_req(0, 1'b1, OP_ADD, a, b);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 50);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_ADD, a, b);
        set_req(1, 1'b1, OP_SUB, b, a);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp0_valid && n < 20);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!rsp0_valid || {rsp0_err, rsp0_result} !== exp0 || req1_ready) begin
                errors++;
                $display("FAIL stall[%0d] got valid=%0b rsp=%h req1_ready=%0b want valid=1 rsp=%h req1_ready=0",
                         c, rsp0_valid, {rsp0_err, rsp0_result}, req1_ready, exp0);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_grant got req1_ready=%b want 1", req1_ready);
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, OP_SUB, b, a);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp1_valid && n < 20);
        checks++;
        if ({rsp1_err, rsp1_result} !== exp1 || !rsp1_valid) begin
            errors++;
            $display("FAIL release_result got %h want %h", {rsp1_err, rsp1_result}, exp1);
        end
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        mlast = 1;
    endtask

    task automatic test_random();
        logic [32:0] rsp, exp;
        int lat, isop, p, exp_lat;
        logic oth, to;
        logic [4:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            p = int'($urandom_range(0, 1));
            op = rand_op();
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            exp = ref_model(op, a, b);
            exp_lat = (op == OP_DIV && b == 0) ? 1 : 2;
            do_op(p, op, a, b, rsp, lat, isop, oth, to);
            mlast = p;
            checks++;
            if (to || rsp !== exp || lat != exp_lat || isop != exp_lat - 1 || oth) begin
                errors++;
                $display("FAIL random[%0d] port %0d op %0d got %h lat=%0d is_op=%0d other=%0b timeout=%0b want %h lat=%0d",
                         i, p, op, rsp, lat, isop, oth, to, exp, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, w;
        logic both, to, seen;
        logic [32:0] rsp, exp;
        set_req(0, 1'b1, OP_MUL, 32'd7, 32'd9);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 50);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_MUL, 32'd7, 32'd9);
        checks++;
        if (alu_is_op !== 1'b1 || alu_val1 !== 32'd7 || alu_val2 !== 32'd9) begin
            errors++;
            $display("FAIL exec_drive got is_op=%b v1=%h v2=%h want 1 7 9", alu_is_op, alu_val1, alu_val2);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, alu_is_op} !== 7'd0 ||
            {rsp0_result, alu_val1, alu_val2, alu_aluop} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ctrl=%b v1=%h v2=%h op=%h res=%h want 0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, alu_is_op},
                     alu_val1, alu_val2, alu_aluop, rsp0_result);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        mlast = 1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_rsp got a response valid want none");
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, OP_ADD, $urandom, $urandom);
        set_req(1, 1'b1, OP_SUB, $urandom, $urandom);
        exp = ref_model(pend_op[0], pend_a[0], pend_b[0]);
        tie_round(w, both, rsp, to);
        mlast = w;
        checks++;
        if (to || w != 0 || rsp !== exp) begin
            errors++;
            $display("FAIL midreset_tie got port %0d rsp=%h timeout=%0b want port 0 rsp=%h", w, rsp, to, exp);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

`ifdef ALU_SCHED_LOCK_EN
    task automatic test_lock();
        int w, exp_w;
        logic both, to;
        logic [32:0] rsp;
        logic l0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mlast = 1;
        set_req(0, 1'b1, OP_ADD, $urandom, $urandom);
        set_req(1, 1'b1, OP_ADD, $urandom, $urandom);
        for (int k = 0; k < 6; k++) begin
            l0 = (k < 3);
            lock0 = l0;
            exp_w = (mlast == 1) ? 0 : 1;
            tie_round(w, both, rsp, to);
            checks++;
            if (to || w != exp_w) begin
                errors++;
                $display("FAIL lock_grant[%0d] got port %0d timeout=%0b want port %0d", k, w, to, exp_w);
            end
            if (!(w == 0 && l0)) mlast = w;
            set_req(w, 1'b1, OP_ADD, $urandom, $urandom);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        lock0 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_divzero();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef ALU_SCHED_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
